// File: rtl/player_shots_pkg.sv
// rtl/player_shots_pkg.sv - shared coordinate width, shot colour and slot state type
package player_shots_pkg;

  localparam int         COORD_W    = 11;
  localparam logic [7:0] SHOT_COLOR = 8'hFF;

  typedef struct packed {
    logic               alive;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } slot_t;

endpackage

// File: rtl/shot_slot.sv
// rtl/shot_slot.sv - one shot slot: position, alive flag, spawn, per-frame move and kill
module shot_slot
  import player_shots_pkg::*;
#(
  parameter int SHOT_SPEED = 4,
  parameter int SPAWN_Y    = 400
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               frame_i,
  input  logic               kill_i,
  input  logic               spawn_i,
  input  logic [COORD_W-1:0] spawn_x_i,
  output slot_t              slot_o
);

  slot_t slot_q, slot_d;

  // Kill beats spawn and move; a shot that would pass above row 0 dies rather than wrapping.
  always_comb begin
    slot_d = slot_q;
    if (clear_i) begin
      slot_d = '0;
    end else if (kill_i) begin
      slot_d.alive = 1'b0;
    end else if (spawn_i) begin
      slot_d.alive = 1'b1;
      slot_d.x     = spawn_x_i;
      slot_d.y     = COORD_W'(SPAWN_Y);
    end else if (frame_i && slot_q.alive) begin
      if (slot_q.y < COORD_W'(SHOT_SPEED)) begin
        slot_d.alive = 1'b0;
      end else begin
        slot_d.y = slot_q.y - COORD_W'(SHOT_SPEED);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/player_multishot_block.sv
// rtl/player_multishot_block.sv - multi-slot player shots: allocation, cooldown, hit test, drawing
module player_multishot_block
  import player_shots_pkg::*;
#(
  parameter int NUM_SHOTS       = 4,
  parameter int SHOT_WIDTH      = 2,
  parameter int SHOT_HEIGHT     = 16,
  parameter int SHOT_SPEED      = 4,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int SPAWN_Y         = 400
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [COORD_W-1:0]               pixelX,
  input  logic [COORD_W-1:0]               pixelY,
  input  logic                             startOfFrame,
  input  logic                             fireCollision,
  input  logic [COORD_W-1:0]               playerXPosition,
  input  logic                             keyRisingEdge,
  input  logic                             standBy,
  input  logic                             gameEnded,
  output logic [7:0]                       playerShotRGB,
  output logic                             playerShotDR,
  output logic [NUM_SHOTS-1:0]             aliveMask,
  output logic [$clog2(NUM_SHOTS+1)-1:0]   shotsInFlight,
  output logic                             fireAccepted
);

  localparam int IDX_W = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1;
  localparam int CNT_W = $clog2(NUM_SHOTS + 1);
  localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam int EXT_W = COORD_W + 1;

  logic                 play_game;
  logic                 clear;
  slot_t                slots [NUM_SHOTS];
  logic [NUM_SHOTS-1:0] alive;
  logic [NUM_SHOTS-1:0] hit;
  logic [NUM_SHOTS-1:0] kill_vec;
  logic [NUM_SHOTS-1:0] spawn_vec;

  logic                 pending_q, pending_d;
  logic [CD_W-1:0]      cd_q, cd_d, cd_dec;
  logic                 dr_q, dr_d;
  logic [IDX_W-1:0]     drawn_q, drawn_d;

  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;
  logic                 spawn_ok;
  logic [CNT_W-1:0]     count;

  assign play_game = ~(standBy | gameEnded);
  assign clear     = ~play_game;

  for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_slot
    logic [EXT_W-1:0] x_ext, y_ext, px_ext, py_ext;

    shot_slot #(
      .SHOT_SPEED (SHOT_SPEED),
      .SPAWN_Y    (SPAWN_Y)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (clear),
      .frame_i   (startOfFrame),
      .kill_i    (kill_vec[g]),
      .spawn_i   (spawn_vec[g]),
      .spawn_x_i (playerXPosition),
      .slot_o    (slots[g])
    );

    assign alive[g] = slots[g].alive;
    assign x_ext    = {1'b0, slots[g].x};
    assign y_ext    = {1'b0, slots[g].y};
    assign px_ext   = {1'b0, pixelX};
    assign py_ext   = {1'b0, pixelY};
    assign hit[g]   = slots[g].alive
                    && (px_ext >= x_ext) && (px_ext < x_ext + EXT_W'(SHOT_WIDTH))
                    && (py_ext >= y_ext) && (py_ext < y_ext + EXT_W'(SHOT_HEIGHT));
  end

  // Free slots are judged on this cycle's alive flags, so a slot dying or being killed now stays unused.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
      if (!alive[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    cd_dec   = (cd_q != '0) ? cd_q - CD_W'(1) : '0;
    spawn_ok = play_game && startOfFrame && pending_q && (cd_dec == '0) && free_found;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      spawn_vec[i] = spawn_ok && (int'(free_idx) == i);
      kill_vec[i]  = fireCollision && dr_q && (int'(drawn_q) == i) && alive[i];
    end
  end

  // Cooldown is tested after this frame's decrement, giving exactly COOLDOWN_FRAMES between spawns.
  always_comb begin
    pending_d = pending_q;
    cd_d      = cd_q;
    if (startOfFrame) begin
      cd_d = spawn_ok ? CD_W'(COOLDOWN_FRAMES) : cd_dec;
      if (pending_q && (cd_dec == '0)) begin
        pending_d = 1'b0;
      end
    end
    if (keyRisingEdge) begin
      pending_d = 1'b1;
    end
    if (!play_game) begin
      pending_d = 1'b0;
      cd_d      = '0;
    end
  end

  always_comb begin
    dr_d    = 1'b0;
    drawn_d = '0;
    for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        dr_d    = 1'b1;
        drawn_d = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      cd_q      <= '0;
      dr_q      <= 1'b0;
      drawn_q   <= '0;
    end else begin
      pending_q <= pending_d;
      cd_q      <= cd_d;
      dr_q      <= dr_d;
      drawn_q   <= drawn_d;
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      count = count + CNT_W'(aliveMask[i]);
    end
  end

  assign aliveMask     = reset ? '0 : alive;
  assign shotsInFlight = count;
  assign playerShotDR  = dr_q & ~reset;
  assign playerShotRGB = playerShotDR ? SHOT_COLOR : 8'h00;
  assign fireAccepted  = spawn_ok & ~reset;

endmodule
